// File: rtl/edid_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : edid_pkg
//  Description : Shared types and constants for the EDID capture block:
//                FSM state encoding, error codes and the fixed EDID header.
//  Revision    : 1.0  initial release
// ============================================================================
package edid_pkg;

   // Capture FSM states (3-bit encoding)
   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_REQ     = 3'd1,
      ST_CAPTURE = 3'd2,
      ST_CHECK   = 3'd3,
      ST_DONE    = 3'd4,
      ST_ERROR   = 3'd5
   } state_t;

   // Values reported on err_code
   localparam logic [1:0] ERR_NONE    = 2'd0;
   localparam logic [1:0] ERR_NACK    = 2'd1;
   localparam logic [1:0] ERR_SHORT   = 2'd2;
   localparam logic [1:0] ERR_TIMEOUT = 2'd3;

   // Fixed EDID header, byte 0 in the most significant position
   localparam int          HDR_LEN  = 8;
   localparam logic [63:0] EDID_HDR = 64'h00FF_FFFF_FFFF_FF00;

   // Expected header byte at position idx (0..7)
   function automatic logic [7:0] hdr_byte(input logic [2:0] idx);
      return EDID_HDR[(63 - 8*int'(idx)) -: 8];
   endfunction

endpackage : edid_pkg
`default_nettype wire

// File: rtl/edid_buf.sv
`default_nettype none
// ============================================================================
//  Module      : edid_buf
//  Description : DEPTH x 8 simple dual-port RAM. One synchronous write port,
//                one read port with a registered output (1-cycle latency).
//                A same-address read/write returns the previous contents.
//  Ports       : clk_i, rst_ni      clock / async active-low reset (output reg)
//                we_i, waddr_i,     write enable, address, data
//                wdata_i
//                raddr_i, rdata_o   read address, registered read data
//  Revision    : 1.0  initial release
// ============================================================================
module edid_buf #(
   parameter int DEPTH = 128,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic          clk_i,
   input  logic          rst_ni,
   input  logic          we_i,
   input  logic [AW-1:0] waddr_i,
   input  logic [7:0]    wdata_i,
   input  logic [AW-1:0] raddr_i,
   output logic [7:0]    rdata_o
);

   logic [7:0] mem_q [DEPTH];

   // Storage array carries no reset so it maps onto block RAM
   always_ff @(posedge clk_i) begin
      if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
   end

   // Read register sees the pre-write value on an address collision
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rdata_o <= 8'h00;
      end else begin
         rdata_o <= mem_q[raddr_i];
      end
   end

endmodule : edid_buf
`default_nettype wire

// File: rtl/edid_capture.sv
`default_nettype none
// ============================================================================
//  Module      : edid_capture
//  Description : Requests one EDID block read from the I2C master, stores the
//                returned bytes, validates header and checksum and exposes
//                the block through a registered random-access read port.
//  Config      : EDID_RETRY_EN  - when defined, failed attempts are retried
//                up to MAX_RETRIES times before err is raised.
//  Ports       : clk_4MHz, rst_n                 clock, async active-low reset
//                start                           capture start pulse
//                req_valid/ready, req_dev,       read request to I2C master
//                req_offset, req_len
//                rx_valid, rx_data               received byte stream
//                xfer_done, xfer_nack            transfer status pulses
//                busy, done, err, err_code       capture status
//                header_ok, checksum_ok          block validation flags
//                rd_addr, rd_data                buffer read port (1 cycle)
//  Revision    : 1.0  initial release
// ============================================================================
module edid_capture
   import edid_pkg::*;
#(
   parameter int         BLOCK_BYTES    = 128,
   parameter logic [6:0] SLAVE_ADDR     = 7'h50,
   parameter int         TIMEOUT_CYCLES = 65535,
   parameter int         MAX_RETRIES    = 3
) (
   input  logic                           clk_4MHz,
   input  logic                           rst_n,
   input  logic                           start,
   output logic                           req_valid,
   input  logic                           req_ready,
   output logic [6:0]                     req_dev,
   output logic [7:0]                     req_offset,
   output logic [8:0]                     req_len,
   input  logic                           rx_valid,
   input  logic [7:0]                     rx_data,
   input  logic                           xfer_done,
   input  logic                           xfer_nack,
   output logic                           busy,
   output logic                           done,
   output logic                           err,
   output logic [1:0]                     err_code,
   output logic                           header_ok,
   output logic                           checksum_ok,
   input  logic [$clog2(BLOCK_BYTES)-1:0] rd_addr,
   output logic [7:0]                     rd_data
);

   localparam int AW = $clog2(BLOCK_BYTES);
   localparam int PW = AW + 1;                       // ptr must reach BLOCK_BYTES
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   localparam int RW = $clog2(MAX_RETRIES + 1) + 1;
   localparam logic [PW-1:0] PTR_FULL = PW'(BLOCK_BYTES);
   localparam logic [TW-1:0] TMO_MAX  = TW'(TIMEOUT_CYCLES);

`ifdef EDID_RETRY_EN
   localparam int RETRY_LIMIT = MAX_RETRIES;
`else
   localparam int RETRY_LIMIT = 0;
`endif

   state_t          state_q;
   logic [PW-1:0]   ptr_q,  ptr_d;
   logic [7:0]      sum_q,  sum_d;
   logic            hdr_q,  hdr_d;
   logic            ovf_q,  ovf_d;
   logic [TW-1:0]   tmo_q,  tmo_d;
   logic [RW-1:0]   retry_q;
   logic            wr_en;
   logic            rx_extra;

   // Byte-arrival bookkeeping; the FSM consumes these next values so a byte
   // arriving together with xfer_done is counted before the length check.
   always_comb begin
      wr_en    = (state_q == ST_CAPTURE) && rx_valid && (ptr_q != PTR_FULL);
      rx_extra = (state_q == ST_CAPTURE) && rx_valid && (ptr_q == PTR_FULL);
      ptr_d    = ptr_q;
      sum_d    = sum_q;
      hdr_d    = hdr_q;
      ovf_d    = ovf_q | rx_extra;
      tmo_d    = tmo_q + 1'b1;
      if (wr_en) begin
         ptr_d = ptr_q + 1'b1;
         sum_d = sum_q + rx_data;
         if (ptr_q < PW'(HDR_LEN) && rx_data != hdr_byte(ptr_q[2:0])) begin
            hdr_d = 1'b0;
         end
      end
   end

   // Main FSM with registered outputs. hdr_q starts at 1 ("all header
   // bytes matched so far") and is ANDed down as header bytes arrive.
   always_ff @(posedge clk_4MHz or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         ptr_q       <= '0;
         sum_q       <= '0;
         hdr_q       <= 1'b0;
         ovf_q       <= 1'b0;
         tmo_q       <= '0;
         retry_q     <= '0;
         req_valid   <= 1'b0;
         req_dev     <= '0;
         req_offset  <= '0;
         req_len     <= '0;
         busy        <= 1'b0;
         done        <= 1'b0;
         err         <= 1'b0;
         err_code    <= ERR_NONE;
         header_ok   <= 1'b0;
         checksum_ok <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE, ST_DONE, ST_ERROR: begin
               if (start) begin
                  state_q     <= ST_REQ;
                  ptr_q       <= '0;
                  sum_q       <= '0;
                  hdr_q       <= 1'b1;
                  ovf_q       <= 1'b0;
                  tmo_q       <= '0;
                  retry_q     <= '0;
                  req_valid   <= 1'b1;
                  req_dev     <= SLAVE_ADDR;
                  req_offset  <= 8'h00;
                  req_len     <= 9'(BLOCK_BYTES);
                  busy        <= 1'b1;
                  done        <= 1'b0;
                  err         <= 1'b0;
                  err_code    <= ERR_NONE;
                  header_ok   <= 1'b0;
                  checksum_ok <= 1'b0;
               end
            end

            ST_REQ: begin
               if (req_ready) begin
                  req_valid <= 1'b0;
                  state_q   <= ST_CAPTURE;
               end
            end

            ST_CAPTURE: begin
               logic       fail;
               logic [1:0] code;
               fail  = 1'b0;
               code  = ERR_NONE;
               ptr_q <= ptr_d;
               sum_q <= sum_d;
               hdr_q <= hdr_d;
               ovf_q <= ovf_d;
               tmo_q <= tmo_d;
               if (xfer_nack) begin
                  fail = 1'b1;
                  code = ERR_NACK;
               end else if (xfer_done) begin
                  if (ptr_d != PTR_FULL || ovf_d) begin
                     fail = 1'b1;
                     code = ERR_SHORT;
                  end else begin
                     state_q <= ST_CHECK;
                  end
               end else if (tmo_d == TMO_MAX) begin
                  fail = 1'b1;
                  code = ERR_TIMEOUT;
               end

               if (fail) begin
                  if (RETRY_LIMIT != 0 && int'(retry_q) < RETRY_LIMIT) begin
                     // Re-issue the request with fresh capture state
                     state_q   <= ST_REQ;
                     retry_q   <= retry_q + 1'b1;
                     ptr_q     <= '0;
                     sum_q     <= '0;
                     hdr_q     <= 1'b1;
                     ovf_q     <= 1'b0;
                     tmo_q     <= '0;
                     req_valid <= 1'b1;
                  end else begin
                     state_q  <= ST_ERROR;
                     busy     <= 1'b0;
                     err      <= 1'b1;
                     err_code <= code;
                  end
               end
            end

            ST_CHECK: begin
               header_ok   <= hdr_q;
               checksum_ok <= (sum_q == 8'h00);
               done        <= 1'b1;
               busy        <= 1'b0;
               state_q     <= ST_DONE;
            end

            default: begin
               state_q <= ST_IDLE;
               busy    <= 1'b0;
            end
         endcase
      end
   end

   edid_buf #(
      .DEPTH (BLOCK_BYTES),
      .AW    (AW)
   ) u_buf (
      .clk_i   (clk_4MHz),
      .rst_ni  (rst_n),
      .we_i    (wr_en),
      .waddr_i (ptr_q[AW-1:0]),
      .wdata_i (rx_data),
      .raddr_i (rd_addr),
      .rdata_o (rd_data)
   );

endmodule : edid_capture
`default_nettype wire

// File: tb/tb_edid_capture.sv
`default_nettype none
// ============================================================================
//  Module      : tb_edid_capture
//  Description : Self-checking bench for edid_capture. Stimulus tasks push
//                expected completion results and read data into queues; a
//                monitor pops and compares when the DUT finishes a capture
//                (busy falls) or a read result becomes visible.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_edid_capture;

   localparam int BLOCK_BYTES = 128;
   localparam int TMO         = 65535;
   localparam int MAX_RETRIES = 3;

   logic       clk_4MHz = 1'b0;
   logic       rst_n;
   logic       start, req_ready, rx_valid, xfer_done, xfer_nack;
   logic [7:0] rx_data;
   logic [6:0] rd_addr;
   logic       req_valid, busy, done, err, header_ok, checksum_ok;
   logic [6:0] req_dev;
   logic [7:0] req_offset, rd_data;
   logic [8:0] req_len;
   logic [1:0] err_code;

   edid_capture #(
      .BLOCK_BYTES    (BLOCK_BYTES),
      .SLAVE_ADDR     (7'h50),
      .TIMEOUT_CYCLES (TMO),
      .MAX_RETRIES    (MAX_RETRIES)
   ) dut (
      .clk_4MHz    (clk_4MHz),
      .rst_n       (rst_n),
      .start       (start),
      .req_valid   (req_valid),
      .req_ready   (req_ready),
      .req_dev     (req_dev),
      .req_offset  (req_offset),
      .req_len     (req_len),
      .rx_valid    (rx_valid),
      .rx_data     (rx_data),
      .xfer_done   (xfer_done),
      .xfer_nack   (xfer_nack),
      .busy        (busy),
      .done        (done),
      .err         (err),
      .err_code    (err_code),
      .header_ok   (header_ok),
      .checksum_ok (checksum_ok),
      .rd_addr     (rd_addr),
      .rd_data     (rd_data)
   );

   always #120 clk_4MHz = ~clk_4MHz;

   typedef struct {
      logic       done;
      logic       err;
      logic [1:0] code;
      logic       hdr;
      logic       cks;
   } res_t;

   res_t       res_q[$];
   logic [7:0] rdq[$];
   logic [7:0] blk [0:129];
   int         n_checks = 0;
   int         n_errors = 0;
   logic       rd_req   = 1'b0;
   logic       rd_pend  = 1'b0;
   logic       busy_prev = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // ---------------- monitor ----------------
   always @(posedge clk_4MHz) rd_pend <= rd_req;

   always @(negedge clk_4MHz) begin
      if (!rst_n) begin
         busy_prev = 1'b0;
      end else begin
         if (busy_prev && !busy) begin
            if (res_q.size() == 0) begin
               check("unexpected_completion", 1, 0);
            end else begin
               res_t e;
               e = res_q.pop_front();
               check("done",        done,        e.done);
               check("err",         err,         e.err);
               check("err_code",    err_code,    e.code);
               check("header_ok",   header_ok,   e.hdr);
               check("checksum_ok", checksum_ok, e.cks);
            end
         end
         busy_prev = busy;
         if (rd_pend) begin
            if (rdq.size() == 0) check("unexpected_read", 1, 0);
            else check("rd_data", rd_data, rdq.pop_front());
         end
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic tick();
      @(posedge clk_4MHz);
      #1;
   endtask

   task automatic make_block(input bit corrupt);
      logic [7:0] s;
      logic [63:0] hdr;
      hdr = 64'h00FF_FFFF_FFFF_FF00;
      s = 8'h00;
      for (int i = 0; i < 127; i++) begin
         if (i < 8) blk[i] = hdr[63 - 8*i -: 8];
         else       blk[i] = 8'(i * 7 + 3);
         s = s + blk[i];
      end
      blk[127] = 8'h00 - s;
      if (corrupt) blk[127] = blk[127] + 8'h01;
      blk[128] = 8'hAA;
      blk[129] = 8'h55;
   endtask

   task automatic expect_res(input logic d, input logic e, input logic [1:0] c,
                             input logic h, input logic k);
      res_t r;
      r.done = d; r.err = e; r.code = c; r.hdr = h; r.cks = k;
      res_q.push_back(r);
   endtask

   task automatic pulse_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   // Wait for req_valid, then accept it three cycles later
   task automatic handshake();
      int n;
      n = 0;
      while (!req_valid && n < 20) begin
         tick();
         n++;
      end
      check("req_valid_seen", req_valid, 1'b1);
      check("req_fields", {req_dev, req_offset, req_len}, {7'h50, 8'h00, 9'd128});
      repeat (3) tick();
      req_ready = 1'b1;
      tick();
      req_ready = 1'b0;
   endtask

   task automatic send_bytes(input int n, input bit done_with_last);
      for (int i = 0; i < n; i++) begin
         rx_valid = 1'b1;
         rx_data  = blk[i];
         if (done_with_last && i == n - 1) xfer_done = 1'b1;
         tick();
      end
      rx_valid  = 1'b0;
      xfer_done = 1'b0;
   endtask

   task automatic pulse_done();
      xfer_done = 1'b1;
      tick();
      xfer_done = 1'b0;
   endtask

   task automatic wait_idle(input int budget);
      int n;
      n = 0;
      while (busy && n < budget) begin
         tick();
         n++;
      end
      check("busy_clears_in_budget", busy, 1'b0);
      tick();
   endtask

   task automatic rd(input logic [6:0] a, input logic [7:0] exp);
      rd_addr = a;
      rdq.push_back(exp);
      rd_req = 1'b1;
      tick();
      rd_req = 1'b0;
      tick();
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_outs"},
            {req_valid, busy, done, err, err_code, header_ok, checksum_ok},
            8'h00);
      check({tag, "_rd_data"}, rd_data, 8'h00);
      check({tag, "_req"}, {req_dev, req_offset, req_len}, 24'h0);
   endtask

   // ---------------- test sequence ----------------
   initial begin
      rst_n = 1'b0; start = 1'b0; req_ready = 1'b0; rx_valid = 1'b0;
      rx_data = 8'h00; xfer_done = 1'b0; xfer_nack = 1'b0; rd_addr = '0;
      repeat (3) tick();
      check_all_zero("reset");
      rst_n = 1'b1;
      tick();

      // 1: valid block, xfer_done together with the last byte
      make_block(1'b0);
      expect_res(1, 0, 2'd0, 1, 1);
      pulse_start();
      handshake();
      send_bytes(128, 1'b1);
      wait_idle(20);
      rd(7'd1, 8'hFF);
      rd(7'd127, blk[127]);

      // 2: checksum byte corrupted, xfer_done one cycle after last byte
      make_block(1'b1);
      expect_res(1, 0, 2'd0, 1, 0);
      pulse_start();
      handshake();
      send_bytes(128, 1'b0);
      pulse_done();
      wait_idle(20);

      // 3: NACK arrives together with xfer_done (nack wins)
      expect_res(0, 1, 2'd1, 0, 0);
      pulse_start();
`ifdef EDID_RETRY_EN
      for (int a = 0; a <= MAX_RETRIES; a++) begin
`else
      for (int a = 0; a < 1; a++) begin
`endif
         handshake();
         xfer_nack = 1'b1;
         xfer_done = 1'b1;
         tick();
         xfer_nack = 1'b0;
         xfer_done = 1'b0;
      end
      wait_idle(20);

      // 4: short transfer
      make_block(1'b0);
      expect_res(0, 1, 2'd2, 0, 0);
      pulse_start();
      handshake();
      send_bytes(100, 1'b0);
      pulse_done();
      wait_idle(20);

      // 5: overflow, 130 bytes; buffer must keep bytes 0..127
      expect_res(0, 1, 2'd2, 0, 0);
      pulse_start();
      handshake();
      send_bytes(130, 1'b0);
      pulse_done();
      wait_idle(20);
      rd(7'd0, 8'h00);
      rd(7'd8, blk[8]);
      rd(7'd127, blk[127]);

      // 6: timeout, request accepted but no xfer_done
      expect_res(0, 1, 2'd3, 0, 0);
      pulse_start();
      handshake();
      wait_idle(TMO + 100);
      check("timeout_busy", busy, 1'b0);

      // 7: reset at byte 40 of a capture, then a fresh valid capture
      pulse_start();
      handshake();
      send_bytes(40, 1'b0);
      rst_n = 1'b0;
      #1;
      check_all_zero("midreset");
      tick();
      rst_n = 1'b1;
      tick();
      expect_res(1, 0, 2'd0, 1, 1);
      pulse_start();
      handshake();
      send_bytes(128, 1'b1);
      wait_idle(20);
      rd(7'd0, 8'h00);
      rd(7'd50, blk[50]);
      rd(7'd127, blk[127]);

      repeat (3) tick();
      check("pending_results", res_q.size(), 0);
      check("pending_reads", rdq.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule : tb_edid_capture
`default_nettype wire

// File: doc/edid_capture.md
Name: edid_capture

Overview:
- Downstream consumer of the I2C master's read path on the HDMI (gpdi) link.
- Requests one EDID read of BLOCK_BYTES bytes from device SLAVE_ADDR starting at offset 0x00, and stores the returned bytes in a local buffer.
- Validates the fixed 8-byte header and the mod-256 checksum, then exposes the block through a random-access read port for the video/config logic.

Parameters:
- BLOCK_BYTES, 128, number of bytes captured per block (power of two, 16..256).
- SLAVE_ADDR, 7'h50, I2C device address placed on the request.
- TIMEOUT_CYCLES, 65535, max clk_4MHz cycles between request accept and xfer_done before timeout.
- MAX_RETRIES, 3, retry limit, used only with EDID_RETRY_EN.

Ports:
- clk_4MHz  in  1  system clock, 4.16667 MHz PLL output; same domain as the I2C master.
- rst_n  in  1  reset.
- start  in  1  single-cycle pulse that begins a capture.
- req_valid  out  1  read request to the I2C master.
- req_ready  in  1  master accepts the request.
- req_dev  out  7  device address, always SLAVE_ADDR.
- req_offset  out  8  register offset, always 0.
- req_len  out  9  byte count, always BLOCK_BYTES.
- rx_valid  in  1  one received byte is present this cycle.
- rx_data  in  8  received byte.
- xfer_done  in  1  pulse: master issued STOP.
- xfer_nack  in  1  pulse: address or register phase NACKed (arrives before or with xfer_done).
- busy  out  1  capture in progress.
- done  out  1  block captured and valid; sticky.
- err  out  1  capture failed; sticky.
- err_code  out  2  0 none, 1 nack, 2 short/overflow, 3 timeout.
- header_ok  out  1  bytes 0..7 equal 00 FF FF FF FF FF FF 00.
- checksum_ok  out  1  sum of all bytes mod 256 equals 0.
- rd_addr  in  log2(BLOCK_BYTES)  read address.
- rd_data  out  8  buffer contents at rd_addr, registered.

Behaviour:
- Interface: one clock, clk_4MHz; reset rst_n is asynchronous, active-low.
- Reset values: all outputs 0, including req_valid, busy, done, err, err_code, header_ok, checksum_ok and rd_data. Buffer contents are undefined after reset.
- States: IDLE, REQ, CAPTURE, CHECK, DONE, ERROR.

State transitions:
- IDLE/DONE/ERROR + start -> REQ. Entering REQ clears done, err, err_code, ptr, sum, hdr_match and the timeout counter.
- start while busy is ignored.
- REQ: req_valid=1 with req_dev, req_offset and req_len stable until the cycle req_valid&&req_ready, then -> CAPTURE.
- CAPTURE, on each rx_valid:
  - Write rx_data at ptr.
  - sum <= sum + rx_data (8-bit wrap).
  - If ptr<8, AND the byte's header-match into hdr_match.
  - ptr increments.
- CAPTURE, rx_valid when ptr==BLOCK_BYTES: byte discarded, overflow flag set.
- CAPTURE exits:
  - xfer_nack -> ERROR with code 1.
  - xfer_done with ptr!=BLOCK_BYTES, or with overflow set -> ERROR with code 2.
  - xfer_done with ptr==BLOCK_BYTES and no overflow -> CHECK.
  - Timeout counter reaching TIMEOUT_CYCLES -> ERROR with code 3.
- rx_valid and xfer_done in the same cycle: the byte is stored and counted first, then xfer_done is evaluated against the updated ptr.
- xfer_nack and xfer_done in the same cycle: nack wins.
- CHECK takes one cycle: header_ok <= hdr_match, checksum_ok <= (sum==0), -> DONE with done=1. A bad checksum or header does not set err; it is reported only through the flags.
- busy=1 in REQ, CAPTURE and CHECK.

Read port:
- rd_data is registered with 1-cycle latency and is valid in every state.
- During CAPTURE it returns partially written contents.
- A read and a write to the same address in the same cycle return the old data.

Optional Feature:
- EDID_RETRY_EN defined: an error (any code) with retry_cnt<MAX_RETRIES returns to REQ, increments retry_cnt and keeps busy=1. err is raised only after the final attempt fails. retry_cnt is cleared on start.
- Macro undefined: the first error goes straight to ERROR.

Decomposition:
- Package edid_pkg:
  - state enum (3 bits).
  - err_code constants NONE/NACK/SHORT/TIMEOUT.
  - EDID header byte array constant.
  - Header length 8.
- Sub-module edid_buf: a BLOCK_BYTES x 8 simple dual-port RAM, one write port and one registered read port, inferable as block RAM.

Test Plan:
- start; master accepts after 3 cycles; 128 bytes of a valid EDID (header, last byte = checksum) then xfer_done -> done=1, header_ok=1, checksum_ok=1, err=0; rd_addr=1 gives rd_data=8'hFF on the next cycle.
- Same transfer with byte 127 corrupted by +1 -> done=1, checksum_ok=0, header_ok=1, err=0.
- xfer_nack after the request is accepted -> err=1, err_code=1, done=0. With EDID_RETRY_EN: 3 further req_valid handshakes, then err=1.
- 100 bytes then xfer_done -> err_code=2. 130 bytes then xfer_done -> err_code=2, buffer bytes 0..127 intact.
- Request accepted, no xfer_done for 65535 cycles -> err_code=3, busy=0.
- rst_n asserted mid-CAPTURE, at byte 40 -> all outputs 0 immediately; after release, a fresh start captures a full valid block correctly.
